// File: rtl/cart_control_mc.sv
// cart_control_mc
//   Cart-side register block for the N64 bus. Holds the global control
//   registers (SCR, VERSION, GPIO, IRQ status/mask, FIFO fill level), NUM_DMA
//   independent debug-DMA channel register sets, and a multi-cycle read path
//   into the USB FIFO. It also turns the N64 reset/NMI lines into a sticky
//   interrupt and forces the cart back into a safe boot configuration.
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_n64_reset, i_n64_nmi  N64 reset/NMI lines (active-low, asynchronous)
//   i_request, i_write      bus request and direction (1 = write)
//   i_address, i_data       11-bit word address, 32-bit write data
//   o_busy, o_ack, o_data   bus handshake and read data (o_ack is a 1-cycle pulse)
//   o_sdram_writable, o_rom_switch, o_config, o_n64_reset_btn   cart control
//   o_irq                   registered interrupt, |(status & mask)
//   o_dma_start, i_dma_busy per-channel start pulse and busy
//   o_dma_bank/address/length  packed per-channel DMA parameters
//   o_fifo_request, i_fifo_data, i_fifo_items   USB FIFO pop interface
module cart_control_mc #(
    parameter int         NUM_DMA      = 2,
    parameter int         FIFO_LATENCY = 2,
    parameter logic [7:0] VERSION      = "b"
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_n64_reset,
    input  logic                    i_n64_nmi,
    input  logic                    i_request,
    input  logic                    i_write,
    output logic                    o_busy,
    output logic                    o_ack,
    input  logic [10:0]             i_address,
    input  logic [31:0]             i_data,
    output logic [31:0]             o_data,
    output logic                    o_sdram_writable,
    output logic                    o_rom_switch,
    output logic [7:0]              o_config,
    output logic                    o_n64_reset_btn,
    output logic                    o_irq,
    output logic [NUM_DMA-1:0]      o_dma_start,
    input  logic [NUM_DMA-1:0]      i_dma_busy,
    output logic [4*NUM_DMA-1:0]    o_dma_bank,
    output logic [24*NUM_DMA-1:0]   o_dma_address,
    output logic [20*NUM_DMA-1:0]   o_dma_length,
    output logic                    o_fifo_request,
    input  logic [31:0]             i_fifo_data,
    input  logic [10:0]             i_fifo_items
);

    // Status/mask layout: one done bit per channel, plus the N64 reset event on top.
    localparam int          SW      = NUM_DMA + 1;
    localparam logic [31:0] ID_WORD = {8'h53, 8'h36, 8'h34, VERSION};
    localparam logic [2:0]  LAT     = 3'(FIFO_LATENCY);

    typedef enum logic {IDLE, FIFO_WAIT} state_t;

    state_t             state;
    logic [2:0]         lat_cnt;
    logic               skip_bootloader;
    logic [SW-1:0]      irq_status;
    logic [SW-1:0]      irq_mask;
    logic [NUM_DMA-1:0] dma_err;
    logic [NUM_DMA-1:0] busy_prev;

    logic n64_reset_p0, n64_reset_p1;
    logic n64_nmi_p0, n64_nmi_p1;
    logic reset_event;

    logic               accept, wr, rd;
    logic               fifo_sel, glob_sel;
    logic [3:0]         page;
    logic [31:0]        rd_data;
    logic [SW-1:0]      status_set, status_clr;
    logic [NUM_DMA-1:0] start_req, err_set, err_clr;

    // Address bits [9:8] alias inside the register window; d[27:26] has no ADDR field.
    logic unused_bits;
    assign unused_bits = ^{i_address[9:8], i_data[27:26]};

    // Two-flop synchronisers; reset to the inactive (high) level so leaving
    // i_reset never produces a spurious reset event.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            n64_reset_p0 <= 1'b1;
            n64_reset_p1 <= 1'b1;
            n64_nmi_p0   <= 1'b1;
            n64_nmi_p1   <= 1'b1;
        end else begin
            n64_reset_p0 <= i_n64_reset;
            n64_reset_p1 <= n64_reset_p0;
            n64_nmi_p0   <= i_n64_nmi;
            n64_nmi_p1   <= n64_nmi_p0;
        end
    end

    assign reset_event = ~n64_reset_p1 | ~n64_nmi_p1;

    // A request is only taken in IDLE; o_busy lags the FIFO accept by one
    // cycle, so the state check is what blocks the cycle in between.
    assign accept   = i_request && !o_busy && (state == IDLE);
    assign wr       = accept && i_write;
    assign rd       = accept && !i_write;
    assign fifo_sel = i_address[10];
    assign page     = i_address[7:4];
    assign glob_sel = !fifo_sel && (page == 4'd0);

    always_comb begin
        rd_data = '0;
        if (glob_sel) begin
            case (i_address[3:0])
                4'd0: rd_data = {21'd0, skip_bootloader, o_config, o_rom_switch, o_sdram_writable};
                4'd1: rd_data = ID_WORD;
                4'd2: rd_data = {29'd0, n64_nmi_p1, n64_reset_p1, ~o_n64_reset_btn};
                4'd3: rd_data = 32'(irq_status);
                4'd4: rd_data = 32'(irq_mask);
                4'd5: rd_data = {21'd0, i_fifo_items};
                default: rd_data = '0;
            endcase
        end else if (!fifo_sel) begin
            for (int c = 0; c < NUM_DMA; c++) begin
                if (page == 4'(c + 1)) begin
                    case (i_address[1:0])
                        2'd0: rd_data = {28'd0, dma_err[c], 1'b0, irq_status[c], i_dma_busy[c]};
                        2'd1: rd_data = {o_dma_bank[4*c +: 4], 2'b00, o_dma_address[24*c +: 24], 2'b00};
                        2'd2: rd_data = {12'd0, o_dma_length[20*c +: 20]};
                        default: rd_data = '0;
                    endcase
                end
            end
        end
    end

    // Sticky-bit set/clear terms. Sets are OR-ed in after clears, so a set
    // always wins against a same-cycle write-1-to-clear.
    always_comb begin
        status_set          = '0;
        status_set[NUM_DMA] = reset_event;
        for (int c = 0; c < NUM_DMA; c++) begin
            status_set[c] = busy_prev[c] & ~i_dma_busy[c];
        end
        status_clr = (wr && glob_sel && (i_address[3:0] == 4'd3)) ? i_data[SW-1:0] : '0;

        start_req = '0;
        err_set   = '0;
        err_clr   = '0;
        for (int c = 0; c < NUM_DMA; c++) begin
            if (wr && !fifo_sel && (page == 4'(c + 1)) && (i_address[1:0] == 2'd0)) begin
                if (i_data[0]) begin
                    // A start is refused while the engine is busy or the
                    // previous start pulse is still on the wire.
                    if (i_dma_busy[c] || o_dma_start[c]) begin
                        err_set[c] = 1'b1;
                    end else begin
                        start_req[c] = 1'b1;
                    end
                end
                err_clr[c] = i_data[3];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state            <= IDLE;
            lat_cnt          <= '0;
            o_busy           <= 1'b0;
            o_ack            <= 1'b0;
            o_data           <= '0;
            o_fifo_request   <= 1'b0;
            o_sdram_writable <= 1'b0;
            o_rom_switch     <= 1'b0;
            o_config         <= '0;
            skip_bootloader  <= 1'b0;
            o_n64_reset_btn  <= 1'b1;
            irq_status       <= '0;
            irq_mask         <= '0;
            o_irq            <= 1'b0;
            o_dma_start      <= '0;
            dma_err          <= '0;
            busy_prev        <= '0;
            o_dma_address    <= '0;
            o_dma_length     <= '0;
            for (int c = 0; c < NUM_DMA; c++) begin
                o_dma_bank[4*c +: 4] <= 4'd1;
            end
        end else begin
            o_ack          <= 1'b0;
            o_fifo_request <= 1'b0;
            busy_prev      <= i_dma_busy;
            irq_status     <= (irq_status & ~status_clr) | status_set;
            dma_err        <= (dma_err & ~err_clr) | err_set;
            o_dma_start    <= reset_event ? '0 : start_req;
            o_irq          <= |(irq_status & irq_mask);

            if (wr && glob_sel) begin
                case (i_address[3:0])
                    4'd0: begin
                        o_sdram_writable <= i_data[0];
                        o_rom_switch     <= i_data[1];
                        o_config         <= i_data[9:2];
                        skip_bootloader  <= i_data[10];
                    end
                    4'd2: o_n64_reset_btn <= ~i_data[0];
                    4'd4: irq_mask        <= i_data[SW-1:0];
                    default: ;
                endcase
            end

            if (wr && !fifo_sel) begin
                for (int c = 0; c < NUM_DMA; c++) begin
                    if (page == 4'(c + 1)) begin
                        case (i_address[1:0])
                            2'd1: begin
                                o_dma_bank[4*c +: 4]     <= i_data[31:28];
                                o_dma_address[24*c +: 24] <= i_data[25:2];
                            end
                            2'd2: o_dma_length[20*c +: 20] <= i_data[19:0];
                            default: ;
                        endcase
                    end
                end
            end

            // Placed after the bus write so it overrides the same fields.
            if (reset_event) begin
                o_sdram_writable <= 1'b0;
                o_rom_switch     <= skip_bootloader;
                o_n64_reset_btn  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rd) begin
                        if (fifo_sel) begin
                            state          <= FIFO_WAIT;
                            lat_cnt        <= '0;
                            o_fifo_request <= 1'b1;
                        end else begin
                            o_data <= rd_data;
                            o_ack  <= 1'b1;
                        end
                    end
                end
                FIFO_WAIT: begin
                    // The pop is seen by the FIFO on the first edge after the
                    // request; data is then valid LAT cycles after that pulse.
                    if (lat_cnt == LAT) begin
                        o_data <= i_fifo_data;
                        o_ack  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                        o_busy  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_control_mc.sv
module tb_cart_control_mc;

    localparam int NUM_DMA = 2;

    logic                  i_clk = 1'b0;
    logic                  i_reset;
    logic                  i_n64_reset;
    logic                  i_n64_nmi;
    logic                  i_request;
    logic                  i_write;
    logic                  o_busy;
    logic                  o_ack;
    logic [10:0]           i_address;
    logic [31:0]           i_data;
    logic [31:0]           o_data;
    logic                  o_sdram_writable;
    logic                  o_rom_switch;
    logic [7:0]            o_config;
    logic                  o_n64_reset_btn;
    logic                  o_irq;
    logic [NUM_DMA-1:0]    o_dma_start;
    logic [NUM_DMA-1:0]    i_dma_busy;
    logic [4*NUM_DMA-1:0]  o_dma_bank;
    logic [24*NUM_DMA-1:0] o_dma_address;
    logic [20*NUM_DMA-1:0] o_dma_length;
    logic                  o_fifo_request;
    logic [31:0]           i_fifo_data;
    logic [10:0]           i_fifo_items;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    cart_control_mc #(
        .NUM_DMA      (NUM_DMA),
        .FIFO_LATENCY (2),
        .VERSION      ("b")
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_n64_reset      (i_n64_reset),
        .i_n64_nmi        (i_n64_nmi),
        .i_request        (i_request),
        .i_write          (i_write),
        .o_busy           (o_busy),
        .o_ack            (o_ack),
        .i_address        (i_address),
        .i_data           (i_data),
        .o_data           (o_data),
        .o_sdram_writable (o_sdram_writable),
        .o_rom_switch     (o_rom_switch),
        .o_config         (o_config),
        .o_n64_reset_btn  (o_n64_reset_btn),
        .o_irq            (o_irq),
        .o_dma_start      (o_dma_start),
        .i_dma_busy       (i_dma_busy),
        .o_dma_bank       (o_dma_bank),
        .o_dma_address    (o_dma_address),
        .o_dma_length     (o_dma_length),
        .o_fifo_request   (o_fifo_request),
        .i_fifo_data      (i_fifo_data),
        .i_fifo_items     (i_fifo_items)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus_write(input logic [10:0] addr, input logic [31:0] data);
        i_request = 1'b1;
        i_write   = 1'b1;
        i_address = addr;
        i_data    = data;
        tick();
        i_request = 1'b0;
        i_write   = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [10:0] addr, input logic [31:0] exp);
        i_request = 1'b1;
        i_write   = 1'b0;
        i_address = addr;
        tick();
        i_request = 1'b0;
        check({tag, "_ack"}, 32'(o_ack), 32'd1);
        check(tag, o_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset      = 1'b1;
        i_n64_reset  = 1'b1;
        i_n64_nmi    = 1'b1;
        i_request    = 1'b0;
        i_write      = 1'b0;
        i_address    = '0;
        i_data       = '0;
        i_dma_busy   = '0;
        i_fifo_data  = 32'hDEADBEEF;
        i_fifo_items = 11'h123;
        tick();
        tick();

        // Reset state
        check("rst_busy",  32'(o_busy), 32'd0);
        check("rst_ack",   32'(o_ack), 32'd0);
        check("rst_btn",   32'(o_n64_reset_btn), 32'd1);
        check("rst_bank",  32'(o_dma_bank), 32'h11);
        check("rst_addr0", 32'(o_dma_address[23:0]), 32'd0);
        check("rst_irq",   32'(o_irq), 32'd0);
        check("rst_start", 32'(o_dma_start), 32'd0);
        check("rst_cfg",   32'(o_config), 32'd0);
        i_reset = 1'b0;
        tick();
        tick();

        // Register reads
        bus_read("rd_version", 11'h001, 32'h53363462);
        tick();
        check("ack_pulse", 32'(o_ack), 32'd0);
        bus_read("rd_ch0_addr", 11'h011, 32'h10000000);
        bus_read("rd_scr0", 11'h000, 32'h0);
        bus_read("rd_items", 11'h005, 32'h123);
        bus_read("rd_unmapped", 11'h006, 32'h0);

        // FIFO read, latency 2, with a second request held during busy
        i_request = 1'b1;
        i_write   = 1'b0;
        i_address = 11'h400;
        tick();
        check("ff_req_e0",  32'(o_fifo_request), 32'd1);
        check("ff_busy_e0", 32'(o_busy), 32'd0);
        check("ff_ack_e0",  32'(o_ack), 32'd0);
        tick();
        check("ff_req_e1",  32'(o_fifo_request), 32'd0);
        check("ff_busy_e1", 32'(o_busy), 32'd1);
        check("ff_ack_e1",  32'(o_ack), 32'd0);
        tick();
        check("ff_busy_e2", 32'(o_busy), 32'd1);
        check("ff_ack_e2",  32'(o_ack), 32'd0);
        check("ff_req_e2",  32'(o_fifo_request), 32'd0);
        tick();
        check("ff_ack_e3",  32'(o_ack), 32'd1);
        check("ff_data_e3", o_data, 32'hDEADBEEF);
        check("ff_busy_e3", 32'(o_busy), 32'd0);
        i_request = 1'b0;
        tick();
        check("ff_ack_e4",  32'(o_ack), 32'd0);
        check("ff_req_e4",  32'(o_fifo_request), 32'd0);

        // Channel 1 setup and start
        bus_write(11'h021, 32'h30000104);
        check("ch1_bank", 32'(o_dma_bank[7:4]), 32'd3);
        check("ch1_addr", 32'(o_dma_address[47:24]), 32'h41);
        check("ch0_bank_kept", 32'(o_dma_bank[3:0]), 32'd1);
        bus_read("rd_ch1_addr", 11'h021, 32'h30000104);
        bus_write(11'h022, 32'h00000100);
        check("ch1_len", 32'(o_dma_length[39:20]), 32'h100);
        bus_write(11'h020, 32'h1);
        check("ch1_start", 32'(o_dma_start), 32'h2);
        tick();
        check("ch1_start_end", 32'(o_dma_start), 32'h0);

        // Busy for 5 cycles, then the falling edge sets done
        i_dma_busy[1] = 1'b1;
        repeat (5) tick();
        i_dma_busy[1] = 1'b0;
        tick();
        bus_read("rd_ch1_ctrl_done", 11'h020, 32'h2);
        bus_write(11'h004, 32'h2);
        check("irq_pre", 32'(o_irq), 32'd0);
        tick();
        check("irq_set", 32'(o_irq), 32'd1);
        bus_read("rd_status", 11'h003, 32'h2);
        bus_write(11'h003, 32'h2);
        tick();
        check("irq_clr", 32'(o_irq), 32'd0);

        // Back-to-back start: second write sees the pulse still high
        bus_write(11'h020, 32'h1);
        bus_write(11'h020, 32'h1);
        check("ch1_b2b_nostart", 32'(o_dma_start), 32'h0);
        bus_read("rd_ch1_err", 11'h020, 32'h8);
        bus_write(11'h020, 32'h8);
        bus_read("rd_ch1_errclr", 11'h020, 32'h0);

        // Channel 0 start while busy
        i_dma_busy[0] = 1'b1;
        bus_write(11'h010, 32'h1);
        check("ch0_nostart", 32'(o_dma_start), 32'h0);
        bus_read("rd_ch0_err", 11'h010, 32'h9);
        bus_write(11'h010, 32'h9);
        bus_read("rd_ch0_setwins", 11'h010, 32'h9);
        bus_write(11'h010, 32'h8);
        bus_read("rd_ch0_errclr", 11'h010, 32'h1);
        i_dma_busy[0] = 1'b0;
        tick();

        // SCR / GPIO, then an NMI pulse through the synchroniser
        bus_write(11'h000, 32'h401);
        bus_write(11'h002, 32'h1);
        check("scr_wr",  32'(o_sdram_writable), 32'd1);
        check("scr_rom", 32'(o_rom_switch), 32'd0);
        check("btn_on",  32'(o_n64_reset_btn), 32'd0);
        bus_read("rd_gpio", 11'h002, 32'h7);
        i_n64_nmi = 1'b0;
        tick();
        tick();
        check("nmi_sync_wr", 32'(o_sdram_writable), 32'd1);
        tick();
        check("nmi_wr",  32'(o_sdram_writable), 32'd0);
        check("nmi_rom", 32'(o_rom_switch), 32'd1);
        check("nmi_btn", 32'(o_n64_reset_btn), 32'd1);
        i_n64_nmi = 1'b1;
        repeat (3) tick();
        bus_read("rd_status_nmi", 11'h003, 32'h5);
        bus_read("rd_scr_nmi", 11'h000, 32'h402);
        bus_read("rd_gpio_nmi", 11'h002, 32'h6);
        check("irq_masked", 32'(o_irq), 32'd0);

        // i_reset in the middle of a FIFO wait
        i_request = 1'b1;
        i_address = 11'h400;
        tick();
        i_request = 1'b0;
        tick();
        check("mid_busy_pre", 32'(o_busy), 32'd1);
        i_reset = 1'b1;
        #1;
        check("mid_busy", 32'(o_busy), 32'd0);
        check("mid_ack",  32'(o_ack), 32'd0);
        tick();
        i_reset = 1'b0;
        tick();
        tick();
        check("mid_noack", 32'(o_ack), 32'd0);

        i_fifo_data = 32'h12345678;
        i_request   = 1'b1;
        i_address   = 11'h400;
        tick();
        i_request = 1'b0;
        check("ff2_req", 32'(o_fifo_request), 32'd1);
        tick();
        tick();
        check("ff2_wait", 32'(o_ack), 32'd0);
        tick();
        check("ff2_ack",  32'(o_ack), 32'd1);
        check("ff2_data", o_data, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
